// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Handshake bundle between the fetch queue, instruction memory and decode.
//   imem request  : o_imem_valid / o_imem_addr / i_imem_ready
//   imem response : i_imem_rvalid / i_imem_rdata (in request order)
//   redirect      : i_redirect / i_redirect_pc
//   decode        : o_instr_valid / o_instr / o_pc / o_pc_plus4 / i_instr_ready
// master = fetch queue side, slave = memory/decode/controller side.
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            o_imem_valid;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ready;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_instr_valid;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_plus4;
    logic            i_instr_ready;

    modport master (
        output o_imem_valid, o_imem_addr,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  i_redirect, i_redirect_pc,
        output o_instr_valid, o_instr, o_pc, o_pc_plus4,
        input  i_instr_ready
    );

    modport slave (
        input  o_imem_valid, o_imem_addr,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output i_redirect, i_redirect_pc,
        input  o_instr_valid, o_instr, o_pc, o_pc_plus4,
        output i_instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front-end: issues in-order word fetches, buffers returned
// instructions with their PCs in a DEPTH-entry queue, presents the head to
// decode, and flushes on redirect while discarding stale in-flight responses.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : fetch_queue_if.master (imem request/response, redirect, decode)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_queue_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];

    logic [SUM_W-1:0] credits_c;
    logic [XLEN-1:0]  redirect_pc_c;
    logic             issue_c;
    logic             accept_c;
    logic             drop_c;
    logic             push_c;
    logic             pop_c;

    // Handshake decode; a request only issues while every queue slot is
    // reserved for at most one buffered, live or stale instruction.
    always_comb begin
        credits_c     = SUM_W'(count_q) + SUM_W'(outst_q) + SUM_W'(discard_q);
        redirect_pc_c = bus.i_redirect_pc & ~XLEN'(3);
        issue_c       = !i_rst && !bus.i_redirect && (credits_c < SUM_W'(DEPTH));
        accept_c      = issue_c && bus.i_imem_ready;
        drop_c        = bus.i_imem_rvalid && (discard_q != '0);
        push_c        = bus.i_imem_rvalid && (discard_q == '0) && !bus.i_redirect;
        pop_c         = (count_q != '0) && bus.i_instr_ready && !bus.i_redirect;
    end

    // Next-state: redirect overrides issue, push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;

        if (bus.i_redirect) begin
            fetch_pc_d = redirect_pc_c;
            resp_pc_d  = redirect_pc_c;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            outst_d    = '0;
            // Live requests become stale; a response landing now is dropped
            // and retires one of them.
            discard_d  = discard_q + outst_q - CNT_W'(bus.i_imem_rvalid);
        end else begin
            if (accept_c) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push_c) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            outst_d   = outst_q + CNT_W'(accept_c) - CNT_W'(push_c);
            discard_d = discard_q - CNT_W'(drop_c);
            count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Control state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q <= XLEN'(RESET_PC);
            resp_pc_q  <= XLEN'(RESET_PC);
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            instr_mem_q[wr_ptr_q] <= bus.i_imem_rdata;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    // Outputs: request driven from fetch_pc, decode side from the head entry.
    assign bus.o_imem_valid  = issue_c;
    assign bus.o_imem_addr   = fetch_pc_q;
    assign bus.o_instr_valid = (count_q != '0);
    assign bus.o_instr       = instr_mem_q[rd_ptr_q];
    assign bus.o_pc          = pc_mem_q[rd_ptr_q];
    assign bus.o_pc_plus4    = pc_mem_q[rd_ptr_q] + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Randomized bench for fetch_queue. A behavioural memory returns responses in
// order; a reference model tracks the delivered-instruction queue and the set
// of pending (live/stale) requests and checks every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int ready_pct = 100;
    int irdy_pct  = 100;
    int lat_min   = 0;
    int lat_max   = 0;

    logic [31:0] exp_fetch;
    ent_t        mq[$];
    req_t        pending[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_p4[$];

    logic        s_iv;
    logic        s_ivld;
    logic [31:0] s_addr;
    logic [31:0] s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return h ^ 32'h1234_5678;
    endfunction

    function automatic bit resp_due();
        if (pending.size() == 0) return 1'b0;
        return pending[0].due <= cyc;
    endfunction

    function automatic int live_inflight();
        int n;
        n = 0;
        foreach (pending[i]) if (!pending[i].stale) n++;
        return n;
    endfunction

    function automatic void model_clear();
        mq.delete();
        pending.delete();
        log_pc.delete();
        log_p4.delete();
        exp_fetch = RESET_PC;
    endfunction

    // One clock cycle: drive inputs at negedge, check against the model, then
    // advance the model with what the coming rising edge will do.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit   rv;
        bit   acc;
        bit   pop_now;
        bit   exp_v;
        req_t r;
        ent_t e;
        @(negedge clk);
        rv = resp_due();
        bus.i_redirect    = redir;
        bus.i_redirect_pc = tgt;
        bus.i_imem_ready  = (int'($urandom_range(0, 99)) < ready_pct);
        bus.i_instr_ready = (int'($urandom_range(0, 99)) < irdy_pct);
        bus.i_imem_rvalid = rv;
        if (rv) bus.i_imem_rdata = mem_word(pending[0].addr);
        else    bus.i_imem_rdata = $urandom();
        #1;
        s_iv   = bus.o_imem_valid;
        s_addr = bus.o_imem_addr;
        s_ivld = bus.o_instr_valid;
        s_pc   = bus.o_pc;

        exp_v = !redir && ((mq.size() + pending.size()) < DEPTH);
        n_cmp++;
        if (s_iv !== exp_v) begin
            n_bad++;
            $display("FAIL imem_valid cyc=%0d got=%0b exp=%0b", cyc, s_iv, exp_v);
        end
        n_cmp++;
        if (s_ivld !== (mq.size() != 0)) begin
            n_bad++;
            $display("FAIL instr_valid cyc=%0d got=%0b exp=%0b", cyc, s_ivld, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            n_cmp++;
            if (bus.o_pc !== mq[0].pc || bus.o_instr !== mq[0].instr ||
                bus.o_pc_plus4 !== (mq[0].pc + 32'd4)) begin
                n_bad++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h p4=%h exp pc=%h instr=%h p4=%h",
                         cyc, bus.o_pc, bus.o_instr, bus.o_pc_plus4,
                         mq[0].pc, mq[0].instr, mq[0].pc + 32'd4);
            end
        end
        acc = s_iv && bus.i_imem_ready && !redir;
        if (acc) begin
            n_cmp++;
            if (s_addr !== exp_fetch) begin
                n_bad++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_fetch);
            end
        end

        if (redir) begin
            mq.delete();
            if (rv) void'(pending.pop_front());
            foreach (pending[i]) pending[i].stale = 1'b1;
            exp_fetch = {tgt[31:2], 2'b00};
        end else begin
            pop_now = (mq.size() != 0) && bus.i_instr_ready;
            if (pop_now) begin
                log_pc.push_back(bus.o_pc);
                log_p4.push_back(bus.o_pc_plus4);
                void'(mq.pop_front());
            end
            if (rv) begin
                r = pending.pop_front();
                if (!r.stale) begin
                    e.pc    = r.addr;
                    e.instr = mem_word(r.addr);
                    mq.push_back(e);
                end
            end
            if (acc) begin
                r.addr  = s_addr;
                r.stale = 1'b0;
                r.due   = cyc + 1 + int'($urandom_range(lat_min, lat_max));
                pending.push_back(r);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_imem_ready  = 1'b1;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = '0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (bus.o_imem_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_imem_valid got=%0b exp=0", bus.o_imem_valid);
        end
        n_cmp++;
        if (bus.o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_instr_valid got=%0b exp=0", bus.o_instr_valid);
        end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, '0);
        n_cmp++;
        if (s_iv !== 1'b1 || s_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL first_req got valid=%0b addr=%h exp valid=1 addr=%h", s_iv, s_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        ready_pct = 100; irdy_pct = 100; lat_min = 0; lat_max = 0;
        repeat (30) step(1'b0, '0);
        n_cmp++;
        if (log_pc.size() < 15) begin
            n_bad++;
            $display("FAIL stream_count got=%0d exp>=15", log_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (log_pc[i] !== RESET_PC + 32'(4 * i) || log_p4[i] !== RESET_PC + 32'(4 * i + 4)) begin
                    n_bad++;
                    $display("FAIL stream_pc%0d got pc=%h p4=%h exp pc=%h p4=%h", i, log_pc[i], log_p4[i],
                             RESET_PC + 32'(4 * i), RESET_PC + 32'(4 * i + 4));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] prev;
        int          n0;
        prev = (log_pc.size() != 0) ? log_pc[log_pc.size() - 1] : 32'hDEAD_BEEF;
        n0   = log_pc.size();
        irdy_pct = 0;
        repeat (10) step(1'b0, '0);
        n_cmp++;
        if (s_iv !== 1'b0 || s_ivld !== 1'b1 || log_pc.size() != n0) begin
            n_bad++;
            $display("FAIL stall_hold got imem_valid=%0b instr_valid=%0b popped=%0d exp 0 1 0",
                     s_iv, s_ivld, log_pc.size() - n0);
        end
        irdy_pct = 100;
        repeat (20) step(1'b0, '0);
        n_cmp++;
        if (log_pc.size() < n0 + 2) begin
            n_bad++;
            $display("FAIL stall_resume got=%0d exp>=2", log_pc.size() - n0);
        end else if (log_pc[n0] !== prev + 32'd4 || log_pc[n0 + 1] !== prev + 32'd8) begin
            n_bad++;
            $display("FAIL stall_order got=%h,%h exp=%h,%h", log_pc[n0], log_pc[n0 + 1], prev + 32'd4, prev + 32'd8);
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        found = 1'b0;
        lat_min = 3; lat_max = 3; irdy_pct = 100; ready_pct = 100;
        for (int i = 0; i < 60 && !found; i++) begin
            if (live_inflight() == 2 && !resp_due()) begin
                step(1'b1, 32'h0000_0100);
                found = 1'b1;
            end else begin
                step(1'b0, '0);
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL redir_inflight_setup got=0 exp=1");
        end
        log_pc.delete(); log_p4.delete();
        repeat (30) step(1'b0, '0);
        n_cmp++;
        if (log_pc.size() < 2) begin
            n_bad++;
            $display("FAIL redir_inflight_count got=%0d exp>=2", log_pc.size());
        end else if (log_pc[0] !== 32'h100 || log_pc[1] !== 32'h104) begin
            n_bad++;
            $display("FAIL redir_inflight_pc got=%h,%h exp=00000100,00000104", log_pc[0], log_pc[1]);
        end
    endtask

    task automatic test_redirect_collide();
        bit found;
        found = 1'b0;
        lat_min = 0; lat_max = 0; irdy_pct = 100; ready_pct = 100;
        for (int i = 0; i < 60 && !found; i++) begin
            if (resp_due() && mq.size() != 0 && i > 10) begin
                step(1'b1, 32'h0000_0203);
                found = 1'b1;
            end else begin
                step(1'b0, '0);
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL redir_collide_setup got=0 exp=1");
        end
        step(1'b0, '0);
        n_cmp++;
        if (s_iv !== 1'b1 || s_addr !== 32'h200 || s_ivld !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_collide_n1 got valid=%0b addr=%h ivld=%0b exp 1 00000200 0", s_iv, s_addr, s_ivld);
        end
        step(1'b0, '0);
        n_cmp++;
        if (s_ivld !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_collide_n2 got ivld=%0b exp=0", s_ivld);
        end
        step(1'b0, '0);
        n_cmp++;
        if (s_ivld !== 1'b1 || s_pc !== 32'h200) begin
            n_bad++;
            $display("FAIL redir_collide_n3 got ivld=%0b pc=%h exp 1 00000200", s_ivld, s_pc);
        end
        repeat (5) step(1'b0, '0);
    endtask

    task automatic test_wrap();
        lat_min = 0; lat_max = 0; irdy_pct = 100; ready_pct = 100;
        step(1'b1, 32'hFFFF_FFFC);
        log_pc.delete(); log_p4.delete();
        repeat (20) step(1'b0, '0);
        n_cmp++;
        if (log_pc.size() < 2) begin
            n_bad++;
            $display("FAIL wrap_count got=%0d exp>=2", log_pc.size());
        end else if (log_pc[0] !== 32'hFFFF_FFFC || log_p4[0] !== 32'h0 || log_pc[1] !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap got pc0=%h p4_0=%h pc1=%h exp fffffffc 00000000 00000000",
                     log_pc[0], log_p4[0], log_pc[1]);
        end
    endtask

    task automatic test_async_reset();
        lat_min = 0; lat_max = 0; irdy_pct = 0; ready_pct = 100;
        repeat (8) step(1'b0, '0);
        n_cmp++;
        if (s_ivld !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre got ivld=%0b exp=1", s_ivld);
        end
        #3;
        rst = 1'b1;
        bus.i_imem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_imem_valid !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_drop got imem_valid=%0b instr_valid=%0b exp 0 0",
                     bus.o_imem_valid, bus.o_instr_valid);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        irdy_pct = 100;
        repeat (12) step(1'b0, '0);
        n_cmp++;
        if (log_pc.size() < 2 || log_pc[0] !== RESET_PC || log_pc[1] !== RESET_PC + 32'd4) begin
            n_bad++;
            $display("FAIL areset_restart got n=%0d pc0=%h exp n>=2 pc0=%h",
                     log_pc.size(), (log_pc.size() != 0) ? log_pc[0] : 32'hX, RESET_PC);
        end
    endtask

    task automatic test_random();
        int n0;
        n0 = 0;
        log_pc.delete(); log_p4.delete();
        ready_pct = 70; irdy_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) step(1'b1, $urandom());
            else                           step(1'b0, '0);
        end
        n0 = log_pc.size();
        n_cmp++;
        if (n0 < 100) begin
            n_bad++;
            $display("FAIL random_progress got=%0d exp>=100", n0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
